// File: rtl/ifu_prefetch.sv
`default_nettype none
// ============================================================================
// Module  : ifu_prefetch
// Brief   : Prefetching RV32I fetch unit with a DEPTH-entry instruction queue.
//           Optional ebreak halt is built when IFU_EBREAK_HALT_EN is defined.
// Rev     : 1.0  initial release
// ============================================================================
module ifu_prefetch #(
  parameter int               WIDTH    = 32,
  parameter int               DEPTH    = 4,
  parameter logic [WIDTH-1:0] RESET_PC = 32'h80000000
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req_valid,
  input  logic             imem_req_ready,
  output logic [WIDTH-1:0] imem_req_addr,
  input  logic             imem_rsp_valid,
  input  logic [31:0]      imem_rsp_data,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_pc,
  output logic [31:0]      out_instr,
  output logic             ebreak,
  output logic             halted
);

  localparam int          c_PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int          c_CNT_W  = $clog2(DEPTH + 1);
  localparam logic [31:0] c_EBREAK = 32'h00100073;

  logic [WIDTH-1:0]   r_fetch_pc;
  logic [WIDTH-1:0]   r_rsp_pc;
  logic [c_CNT_W-1:0] r_inflight;
  logic [c_CNT_W-1:0] r_drop;
  logic [c_CNT_W-1:0] r_count;
  logic [c_PTR_W-1:0] r_head;
  logic [c_PTR_W-1:0] r_tail;
  logic [WIDTH-1:0]   r_q_pc    [DEPTH];
  logic [31:0]        r_q_instr [DEPTH];

  logic               w_halted;
  logic               w_halt_set;
  logic               w_flush;
  logic               w_req_fire;
  logic               w_deq;
  logic               w_enq;
  logic               w_rsp_drop;
  logic [c_CNT_W:0]   w_occ;
  logic [c_CNT_W-1:0] w_inflight_nxt;
  logic [WIDTH-1:0]   w_target;
  logic               w_unused;

  assign w_target = {redirect_pc[WIDTH-1:2], 2'b00};
  assign w_unused = &{1'b0, redirect_pc[1:0]};

  // Buffered plus outstanding fetches never exceed DEPTH, so enqueue cannot overflow.
  assign w_occ          = {1'b0, r_count} + {1'b0, r_inflight};
  assign imem_req_valid = !rst && !redirect_valid && !w_halted &&
                          (w_occ < (c_CNT_W+1)'(DEPTH));
  assign imem_req_addr  = rst ? '0 : r_fetch_pc;

  assign out_valid = (r_count != '0);
  assign out_pc    = out_valid ? r_q_pc[r_head]    : '0;
  assign out_instr = out_valid ? r_q_instr[r_head] : '0;
  assign ebreak    = out_valid && (r_q_instr[r_head] == c_EBREAK);

  assign w_req_fire     = imem_req_valid && imem_req_ready;
  assign w_deq          = out_valid && out_ready;
  assign w_flush        = redirect_valid || w_halt_set;
  assign w_rsp_drop     = imem_rsp_valid && (r_drop != '0);
  assign w_enq          = imem_rsp_valid && (r_drop == '0) && !w_flush;
  assign w_inflight_nxt = r_inflight + c_CNT_W'(w_req_fire) - c_CNT_W'(imem_rsp_valid);

`ifdef IFU_EBREAK_HALT_EN
  logic r_halted;

  // A dequeue that coincides with a redirect is consumed without side effects.
  assign w_halt_set = w_deq && ebreak && !redirect_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_halted <= 1'b0;
    end else if (redirect_valid) begin
      r_halted <= 1'b0;
    end else if (w_halt_set) begin
      r_halted <= 1'b1;
    end
  end

  assign w_halted = r_halted;
`else
  assign w_halt_set = 1'b0;
  assign w_halted   = 1'b0;
`endif

  assign halted = w_halted;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc <= RESET_PC;
      r_rsp_pc   <= RESET_PC;
      r_inflight <= '0;
      r_drop     <= '0;
      r_count    <= '0;
      r_head     <= '0;
      r_tail     <= '0;
    end else begin
      r_inflight <= w_inflight_nxt;
      if (w_req_fire) begin
        r_fetch_pc <= r_fetch_pc + WIDTH'(4);
      end
      if (w_flush) begin
        // Everything still outstanding after this cycle is stale.
        r_count <= '0;
        r_head  <= '0;
        r_tail  <= '0;
        r_drop  <= w_inflight_nxt;
        if (redirect_valid) begin
          r_fetch_pc <= w_target;
          r_rsp_pc   <= w_target;
        end
      end else begin
        if (w_rsp_drop) begin
          r_drop <= r_drop - c_CNT_W'(1);
        end
        if (w_enq) begin
          r_tail   <= r_tail + c_PTR_W'(1);
          r_rsp_pc <= r_rsp_pc + WIDTH'(4);
        end
        if (w_deq) begin
          r_head <= r_head + c_PTR_W'(1);
        end
        case ({w_enq, w_deq})
          2'b10:   r_count <= r_count + c_CNT_W'(1);
          2'b01:   r_count <= r_count - c_CNT_W'(1);
          default: r_count <= r_count;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_q_pc[r_tail]    <= r_rsp_pc;
      r_q_instr[r_tail] <= imem_rsp_data;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ifu_prefetch.sv
`default_nettype none
// ============================================================================
// Module  : tb_ifu_prefetch
// Brief   : Scoreboard bench for ifu_prefetch with an in-order memory model.
// Rev     : 1.0  initial release
// ============================================================================
module tb_ifu_prefetch;

  localparam int          WIDTH       = 32;
  localparam int          DEPTH       = 4;
  localparam logic [31:0] RESET_PC    = 32'h80000000;
  localparam logic [31:0] EBREAK_INSN = 32'h00100073;
  localparam logic [31:0] EBRK_ADDR   = 32'h80004000;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             imem_req_valid;
  logic             imem_req_ready = 1'b0;
  logic [WIDTH-1:0] imem_req_addr;
  logic             imem_rsp_valid = 1'b0;
  logic [31:0]      imem_rsp_data = 32'h0;
  logic             redirect_valid = 1'b0;
  logic [WIDTH-1:0] redirect_pc = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_pc;
  logic [31:0]      out_instr;
  logic             ebreak;
  logic             halted;

  ifu_prefetch #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_instr(out_instr),
    .ebreak(ebreak), .halted(halted)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] pc; logic [31:0] instr; } exp_t;
  typedef struct { logic [31:0] addr; int gen; longint due; } mreq_t;

  exp_t        expq[$];
  mreq_t       memq[$];
  int          nchecks = 0;
  int          nerr = 0;
  int          gen = 0;
  int          inflight_m = 0;
  int          qocc = 0;
  bit          halted_m = 0;
  logic [31:0] fetch_m = RESET_PC;
  longint      cyc = 0;
  longint      last_due = 0;
  int          lat_min = 1;
  int          lat_max = 1;
  int          nreq = 0;
  int          ndeq = 0;
  logic [31:0] last_deq_pc = 32'h0;
  bit          saw_wrap = 0;
  bit          saw_ebreak = 0;

  // Instruction memory contents: a fixed scramble of the address, ebreak at EBRK_ADDR.
  function automatic logic [31:0] memf(input logic [31:0] a);
    logic [31:0] v;
    if (a == EBRK_ADDR) return EBREAK_INSN;
    v = {a[15:0] ^ 16'hA5C3, a[31:16] ^ a[15:0]};
    if (v == EBREAK_INSN) v = v ^ 32'h1;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    nchecks++;
    if (act !== req) begin
      nerr++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic redirect_to(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    step();
    redirect_valid = 1'b0;
  endtask

  // Memory: answers requests in order once their due cycle is reached.
  always @(posedge clk) begin
    cyc++;
    #1;
    if (memq.size() != 0 && memq[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = memf(memq[0].addr);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
  end

  // Reference model: issue rule, request addresses and expected-instruction stream.
  always @(negedge clk) begin
    longint due;
    if (rst) begin
      expq.delete();
      memq.delete();
      gen++;
      inflight_m = 0;
      qocc       = 0;
      halted_m   = 0;
      fetch_m    = RESET_PC;
      last_due   = 0;
    end else begin
      chk("req_valid", {31'b0, imem_req_valid},
          {31'b0, !redirect_valid && !halted_m && (qocc + inflight_m < DEPTH)});
      chk("halted", {31'b0, halted}, {31'b0, halted_m});
      if (qocc + inflight_m > DEPTH) chk("occupancy_bound", qocc + inflight_m, DEPTH);
      if (imem_rsp_valid && memq.size() != 0) begin
        mreq_t m;
        m = memq.pop_front();
        inflight_m--;
        if (!redirect_valid && m.gen == gen) qocc++;
      end
      if (imem_req_valid && imem_req_ready) begin
        chk("req_addr", imem_req_addr, fetch_m);
        expq.push_back('{fetch_m, memf(fetch_m)});
        due = cyc + longint'($urandom_range(lat_max, lat_min));
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        memq.push_back('{imem_req_addr, gen, due});
        if (fetch_m == 32'h0) saw_wrap = 1;
        fetch_m = fetch_m + 32'd4;
        inflight_m++;
        nreq++;
      end
      if (redirect_valid) begin
        expq.delete();
        gen++;
        qocc     = 0;
        halted_m = 0;
        fetch_m  = redirect_pc & ~32'h3;
      end
    end
  end

  // Monitor: pops the scoreboard on every decode handshake.
  always @(negedge clk) begin
    exp_t e;
    #1;
    if (!rst) begin
      if (!out_valid) begin
        chk("idle_outputs_zero", out_pc | out_instr | {31'b0, ebreak}, 32'h0);
      end else if (out_ready && !redirect_valid) begin
        if (expq.size() == 0) begin
          nchecks++;
          nerr++;
          $display("FAIL unexpected_out: got pc %h with nothing expected", out_pc);
        end else begin
          e = expq.pop_front();
          chk("out_pc", out_pc, e.pc);
          chk("out_instr", out_instr, e.instr);
          chk("out_ebreak", {31'b0, ebreak}, {31'b0, e.instr == EBREAK_INSN});
          qocc--;
          ndeq++;
          last_deq_pc = out_pc;
          if (e.instr == EBREAK_INSN) begin
            saw_ebreak = 1;
`ifdef IFU_EBREAK_HALT_EN
            expq.delete();
            gen++;
            qocc     = 0;
            halted_m = 1;
`endif
          end
        end
      end
    end
  end

  initial begin
    int n0;
    int r0;
    int i;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", {31'b0, out_valid}, 32'h0);
    chk("rst_req_valid", {31'b0, imem_req_valid}, 32'h0);
    chk("rst_req_addr", imem_req_addr, 32'h0);
    chk("rst_out_pc", out_pc, 32'h0);
    chk("rst_out_instr", out_instr, 32'h0);
    chk("rst_ebreak", {31'b0, ebreak}, 32'h0);
    chk("rst_halted", {31'b0, halted}, 32'h0);

    // Streaming with single-cycle memory: one instruction per cycle
    step();
    rst = 1'b0;
    imem_req_ready = 1'b1;
    out_ready = 1'b1;
    repeat (10) step();
    n0 = ndeq;
    repeat (30) step();
    chk("throughput_30", ndeq - n0, 30);

    // Decode stalled: exactly DEPTH requests, then issue stops
    out_ready = 1'b0;
    redirect_to(RESET_PC);
    r0 = nreq;
    repeat (15) step();
    chk("stall_req_count", nreq - r0, DEPTH);
    chk("stall_req_valid", {31'b0, imem_req_valid}, 32'h0);
    out_ready = 1'b1;
    n0 = ndeq;
    repeat (10) step();
    chk("resume_deq", {31'b0, (ndeq - n0) >= DEPTH}, 32'h1);
    chk("resume_req", {31'b0, nreq > r0 + DEPTH}, 32'h1);

    // Three-cycle memory, redirect with three fetches in flight
    lat_min = 3;
    lat_max = 3;
    for (i = 0; i < 50 && inflight_m != 3; i++) step();
    chk("inflight_reached_3", inflight_m, 3);
    n0 = ndeq;
    redirect_to(32'h80000102);
    for (i = 0; i < 40 && ndeq == n0; i++) step();
    chk("first_pc_after_redirect", last_deq_pc, 32'h80000100);

    // Redirect coinciding with a response and a decode handshake
    lat_min = 1;
    lat_max = 1;
    for (i = 0; i < 50 && !(imem_rsp_valid && out_valid); i++) step();
    chk("collision_setup", {31'b0, imem_rsp_valid && out_valid}, 32'h1);
    redirect_to(32'h80000200);
    chk("collision_queue_empty", {31'b0, out_valid}, 32'h0);
    repeat (10) step();

    // Address wrap at the top of the space
    redirect_to(32'hFFFFFFF4);
    for (i = 0; i < 20 && !saw_wrap; i++) step();
    chk("wrap_to_zero", {31'b0, saw_wrap}, 32'h1);
    repeat (5) step();

    // ebreak at the queue head
    redirect_to(EBRK_ADDR - 32'd8);
    for (i = 0; i < 40 && !saw_ebreak; i++) step();
    chk("ebreak_seen", {31'b0, saw_ebreak}, 32'h1);
    step();
    step();
`ifdef IFU_EBREAK_HALT_EN
    chk("halt_asserted", {31'b0, halted}, 32'h1);
    r0 = nreq;
    repeat (10) step();
    chk("halt_no_requests", nreq, r0);
    redirect_to(RESET_PC);
    repeat (6) step();
    chk("halt_restart", {31'b0, nreq > r0}, 32'h1);
`else
    r0 = nreq;
    repeat (10) step();
    chk("no_halt_fetch_continues", {31'b0, nreq > r0}, 32'h1);
`endif

    // Randomized traffic
    lat_min = 1;
    lat_max = 4;
    for (int k = 0; k < 1500; k++) begin
      imem_req_ready = ($urandom_range(3, 0) != 0);
      out_ready      = ($urandom_range(2, 0) != 0);
      if ($urandom_range(29, 0) == 0) begin
        redirect_valid = 1'b1;
        redirect_pc    = RESET_PC + {$urandom_range(255, 0), 2'b00} + 32'($urandom_range(3, 0));
      end else begin
        redirect_valid = 1'b0;
      end
      step();
    end
    redirect_valid = 1'b0;
    imem_req_ready = 1'b1;
    out_ready = 1'b1;
    repeat (20) step();

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

endmodule
`default_nettype wire
